// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Lookup for the IF stage is combinational; EX feeds
// back each resolved control instruction to train the table, raise the
// mispredict flag, supply the redirect PC and advance the statistics.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int PRED_MODE = 1,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_if,
    output logic             o_pred_taken,
    output logic [31:0]      o_pred_target,
    input  logic             i_upd_vld,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_taken,
    input  logic [31:0]      i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [31:0]      i_upd_pred_target,
    input  logic             i_flush_tbl,
    output logic             o_mispred,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_BITS + 1;
    localparam int WT_INT = 1 << (CTR_BITS - 1);
    localparam bit DYN    = (PRED_MODE != 0);

    // Weakly taken = MSB set, rest clear; weakly not-taken = MSB clear, rest set.
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(WT_INT);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(WT_INT - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    // Table storage
    logic                valid_reg  [ENTRIES];
    logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
    logic [31:0]         target_reg [ENTRIES];
    logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

    logic [CNT_W-1:0]    br_cnt_reg;
    logic [CNT_W-1:0]    mispred_cnt_reg;

    // Fetch-side lookup fields
    logic [IDX_W-1:0]    idx_if;
    logic [TAG_BITS-1:0] tag_if;
    logic                hit_if;
    logic                pred_taken_raw;

    // Resolve-side fields
    logic [IDX_W-1:0]    idx_upd;
    logic [TAG_BITS-1:0] tag_upd;
    logic                hit_upd;
    logic                mispred_raw;

    assign idx_if  = i_pc_if[IDX_W+1:2];
    assign tag_if  = i_pc_if[TAG_HI:TAG_LO];
    assign idx_upd = i_upd_pc[IDX_W+1:2];
    assign tag_upd = i_upd_pc[TAG_HI:TAG_LO];

    // Lookup reads the pre-update table contents; writes land on the next edge.
    always_comb begin
        hit_if         = valid_reg[idx_if] && (tag_reg[idx_if] == tag_if);
        pred_taken_raw = DYN && hit_if && ctr_reg[idx_if][CTR_BITS-1];
        hit_upd        = valid_reg[idx_upd] && (tag_reg[idx_upd] == tag_upd);
    end

    // Outcome differs from what travelled down the pipe: wrong direction,
    // or taken with a wrong target (e.g. jalr to a new address).
    always_comb begin
        mispred_raw = i_upd_vld &&
                      ((i_upd_taken != i_upd_pred_taken) ||
                       (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    end

    // Reset masks the flags combinationally so the flush logic sees a quiet pipe.
    assign o_pred_taken  = pred_taken_raw && !i_reset;
    assign o_pred_target = o_pred_taken ? target_reg[idx_if] : (i_pc_if + 32'd4);
    assign o_mispred     = mispred_raw && !i_reset;
    assign o_redirect_pc = i_upd_taken ? i_upd_target : (i_upd_pc + 32'd4);
    assign o_br_cnt      = br_cnt_reg;
    assign o_mispred_cnt = mispred_cnt_reg;

    // Table training: flush beats update; hits move the counter, taken misses allocate.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= CTR_WNT;
            end
        end else if (DYN && i_flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else if (DYN && i_upd_vld) begin
            if (hit_upd) begin
                if (i_upd_taken) begin
                    if (ctr_reg[idx_upd] != CTR_MAX) begin
                        ctr_reg[idx_upd] <= ctr_reg[idx_upd] + 1'b1;
                    end
                    target_reg[idx_upd] <= i_upd_target;
                end else if (ctr_reg[idx_upd] != CTR_MIN) begin
                    ctr_reg[idx_upd] <= ctr_reg[idx_upd] - 1'b1;
                end
            end else if (i_upd_taken) begin
                valid_reg[idx_upd]  <= 1'b1;
                tag_reg[idx_upd]    <= tag_upd;
                target_reg[idx_upd] <= i_upd_target;
                ctr_reg[idx_upd]    <= CTR_WT;
            end
        end
    end

    // Statistics count every resolved instruction, independent of mode and flush.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            br_cnt_reg      <= '0;
            mispred_cnt_reg <= '0;
        end else if (i_upd_vld) begin
            br_cnt_reg <= br_cnt_reg + 1'b1;
            if (mispred_raw) begin
                mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
            end
        end
    end

endmodule
